mouse_cursor_tracker: RTL and testbench
=======================================

# mouse_cursor_tracker

Parametrised cursor-position engine that consumes decoded 3-byte PS/2 mouse packets and maintains a clamped on-screen cursor position for the VGA overlay. It generalises screen size, clamp window, start position and position width. It adds a valid/ready packet handshake, saturating signed arithmetic, packet sync checking, button state and click pulses, and optional acceleration. It sits between the PS/2 packet assembler and the VGA cursor renderer.

## Interface
- `POS_W`, 10: width of the position outputs.
- `X_MIN`, 10 / `X_MAX`, 600: inclusive horizontal clamp window.
- `Y_MIN`, 6 / `Y_MAX`, 474: inclusive vertical clamp window.
- `X_INIT`, 320 / `Y_INIT`, 240: reset and relock position.
- `ACCEL_THRESH`, 16: magnitude at or above which a delta is doubled (only with `MOUSE_ACCEL_EN`).

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: clock-manager lock; low forces a synchronous reinitialise.
- `pkt_valid` in 1: packet bytes are valid.
- `pkt_ready` out 1: block accepts a packet this cycle.
- `status_byte` in 8: `[7]` Yovf, `[6]` Xovf, `[5]` Ysign, `[4]` Xsign, `[3]` sync (must be 1), `[2]` middle, `[1]` right, `[0]` left.
- `x_byte`, `y_byte` in 8 each: movement magnitude bytes.
- `x_posn`, `y_posn` out POS_W each: cursor position.
- `pos_valid` out 1: one-cycle pulse when a position update is committed.
- `pkt_err` out 1: one-cycle pulse when a packet is rejected for a sync error.
- `btn` out 3: held button state `{middle, right, left}`.
- `click` out 3: one-cycle rising-edge pulses of `btn`.

## Operation
- FSM states: IDLE, SCALE, UPDATE.
- **IDLE**
  - `pkt_ready`=1.
  - On `pkt_valid`&&`pkt_ready` with `status_byte[3]`=1: capture the three bytes and go to SCALE.
  - If `status_byte[3]`=0: pulse `pkt_err` next cycle, stay in IDLE, leave position and buttons unchanged.
- **SCALE**
  - `pkt_ready`=0.
  - Form 9-bit signed deltas `{sign, byte}`.
  - If the overflow bit is set: sign 0 saturates to +255, sign 1 saturates to −256.
  - Apply optional acceleration, producing 11-bit signed deltas.
  - Go to UPDATE.
- **UPDATE**
  - `pkt_ready`=0.
  - Compute x sum = `x_posn` + dx and y sum = `y_posn` − dy (mouse Y up moves the screen up). Use POS_W+3-bit signed arithmetic; intermediate results never wrap.
  - Clamp each sum to its [MIN, MAX] window and register it.
  - Register `btn` from the captured status bits [2:0].
  - `click` = new `btn` & ~old `btn`.
  - Assert `pos_valid`, then go to IDLE.
- `pos_valid` pulses even when the clamped position is unchanged.
- `locked`=0 overrides all other activity, synchronously:
  - state → IDLE
  - position → (`X_INIT`, `Y_INIT`)
  - `btn`, `click`, `pos_valid`, `pkt_err` → 0
  - `pkt_ready` → 0
  - any in-flight packet is discarded.
- Reset values (`rst_n` low): state IDLE, `x_posn`=`X_INIT`, `y_posn`=`Y_INIT`, `pkt_ready`=0, all other outputs 0.
- `pkt_ready` rises the first clock after both `rst_n` and `locked` are high.

## Timing
- Packet accepted at edge k.
- `x_posn`, `y_posn`, `btn`, `click` and `pos_valid` update at edge k+2.
- `pos_valid` and `click` are high for exactly the cycle following edge k+2.
- `pkt_ready` is low between edge k and edge k+2, and high again after edge k+2.
- Maximum throughput is one packet per 3 cycles.
- `pkt_err` is high for the one cycle after the rejecting edge; throughput on rejection is one packet per cycle.
- Holding `pkt_valid` while `pkt_ready`=0 has no effect; the bytes must be held stable until accepted.

## Configuration
- `MOUSE_ACCEL_EN` defined:
  - After saturation, a delta with |d| ≥ `ACCEL_THRESH` is doubled (arithmetic shift left by 1).
  - This applies to saturated values too: −256 becomes −512.
- `MOUSE_ACCEL_EN` undefined: deltas pass through unscaled. The SCALE state still exists, so latency is unchanged.

## Test plan
- **Reset/relock**
  - Stimulus: assert `rst_n`=0, release it, then drop `locked` for 2 cycles in SCALE.
  - Required: position (320,240), no `pos_valid` for the dropped packet, `pkt_ready` high one clock after `locked` returns.
- **Basic move**
  - Stimulus: status 0x08, x 0x05, y 0x03.
  - Required: at edge k+2, (325,237); `pos_valid` for 1 cycle; `pkt_ready` low for exactly 2 cycles.
- **Clamp and overflow**
  - Stimulus: two packets with status 0x08, x 0xFF from (320,240).
  - Required: x goes 575 then 600.
  - Stimulus: then status 0x58.
  - Required: dx=−256, x=344.
- **Negative Y with clamp**
  - Stimulus: status 0x28, y 0xF6.
  - Required: y 240→250.
  - Stimulus: repeat with Yovf (status 0xA8).
  - Required: y saturates to 474.
- **Sync error and clicks**
  - Stimulus: status 0x00.
  - Required: `pkt_err` pulse, no `pos_valid`, position unchanged.
  - Stimulus: then status 0x09 twice.
  - Required: `click`=3'b001 once, `btn`=3'b001 held.
- **Acceleration**
  - Stimulus: status 0x08, x 0x20.
  - Required: x=384 with `MOUSE_ACCEL_EN`, x=352 without.
  - Stimulus: x 0x0F.
  - Required: +15 in both builds.

Source files
------------

// File: rtl/mouse_cursor_tracker_if.sv
// mouse_cursor_tracker_if
// Packet-in / cursor-out bundle between the PS/2 packet assembler, the
// cursor tracker and the VGA cursor renderer.
//   pkt_valid, status_byte, x_byte, y_byte : decoded 3-byte PS/2 packet
//   pkt_ready                              : tracker accepts a packet
//   x_posn, y_posn                         : clamped cursor position
//   pos_valid                              : pulse on each committed update
//   pkt_err                                : pulse on a sync-bit rejection
//   btn, click                             : held buttons / rising-edge pulses
// Modports: master = packet source + cursor consumer, slave = tracker.
interface mouse_cursor_tracker_if #(
  parameter int POS_W = 10
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [7:0]       status_byte;
  logic [7:0]       x_byte;
  logic [7:0]       y_byte;
  logic [POS_W-1:0] x_posn;
  logic [POS_W-1:0] y_posn;
  logic             pos_valid;
  logic             pkt_err;
  logic [2:0]       btn;
  logic [2:0]       click;

  modport master (
    output pkt_valid, status_byte, x_byte, y_byte,
    input  pkt_ready, x_posn, y_posn, pos_valid, pkt_err, btn, click
  );

  modport slave (
    input  pkt_valid, status_byte, x_byte, y_byte,
    output pkt_ready, x_posn, y_posn, pos_valid, pkt_err, btn, click
  );
endinterface

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
// Consumes decoded PS/2 mouse packets and maintains a clamped cursor
// position plus button state for the VGA overlay.
// Ports:
//   clk    : block clock
//   rst_n  : asynchronous active-low reset
//   locked : clock-manager lock; low forces a synchronous reinitialise
//   bus    : mouse_cursor_tracker_if.slave (packet in, cursor/buttons out)
// Optional feature: define MOUSE_ACCEL_EN to double any delta whose
// magnitude is at or above ACCEL_THRESH (applied after saturation).
// Latency: packet accepted at edge k, outputs committed at edge k+2.
// POS_W must be at least 8 so the POS_W+3 sum covers the 11-bit deltas.
module mouse_cursor_tracker #(
  parameter int POS_W        = 10,
  parameter int X_MIN        = 10,
  parameter int X_MAX        = 600,
  parameter int Y_MIN        = 6,
  parameter int Y_MAX        = 474,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int ACCEL_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  mouse_cursor_tracker_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCALE  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam int SUM_W = POS_W + 3;

`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam logic [POS_W-1:0]        X_INIT_P = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]        Y_INIT_P = POS_W'(Y_INIT);
  localparam logic signed [SUM_W-1:0] X_MIN_S  = SUM_W'(X_MIN);
  localparam logic signed [SUM_W-1:0] X_MAX_S  = SUM_W'(X_MAX);
  localparam logic signed [SUM_W-1:0] Y_MIN_S  = SUM_W'(Y_MIN);
  localparam logic signed [SUM_W-1:0] Y_MAX_S  = SUM_W'(Y_MAX);
  localparam logic signed [10:0]      ACCEL_T  = 11'(ACCEL_THRESH);

  logic [1:0]        state_reg;
  logic [3:0]        motion_reg;   // {Yovf, Xovf, Ysign, Xsign}
  logic [2:0]        btn_cap_reg;
  logic [7:0]        x_byte_reg;
  logic [7:0]        y_byte_reg;
  logic signed [10:0] dx_reg;
  logic signed [10:0] dy_reg;
  logic [POS_W-1:0]  x_posn_reg;
  logic [POS_W-1:0]  y_posn_reg;
  logic [2:0]        btn_reg;
  logic [2:0]        click_reg;
  logic              pos_valid_reg;
  logic              pkt_err_reg;
  logic              ready_reg;

  // Sign-extend the byte with its sign bit, saturate on overflow, then
  // optionally double large moves. -256 doubles to -512, hence 11 bits.
  function automatic logic signed [10:0] scale_delta(
    input logic       ovf,
    input logic       sgn,
    input logic [7:0] mag
  );
    logic signed [10:0] d;
    logic signed [10:0] a;
    if (ovf)
      d = sgn ? -11'sd256 : 11'sd255;
    else
      d = {{3{sgn}}, mag};
    a = (d < 11'sd0) ? -d : d;
    if (ACCEL_ON && (a >= ACCEL_T))
      d = d <<< 1;
    return d;
  endfunction

  function automatic logic signed [SUM_W-1:0] clamp(
    input logic signed [SUM_W-1:0] s,
    input logic signed [SUM_W-1:0] lo,
    input logic signed [SUM_W-1:0] hi
  );
    if (s < lo)
      return lo;
    else if (s > hi)
      return hi;
    else
      return s;
  endfunction

  // Sums are wide enough that neither +510 nor -512 from any position wraps.
  logic signed [SUM_W-1:0] x_sum_c;
  logic signed [SUM_W-1:0] y_sum_c;
  logic signed [SUM_W-1:0] x_clamp_c;
  logic signed [SUM_W-1:0] y_clamp_c;

  always_comb begin
    x_sum_c   = $signed({3'b000, x_posn_reg}) + SUM_W'(dx_reg);
    // Mouse Y grows upward, screen Y grows downward.
    y_sum_c   = $signed({3'b000, y_posn_reg}) - SUM_W'(dy_reg);
    x_clamp_c = clamp(x_sum_c, X_MIN_S, X_MAX_S);
    y_clamp_c = clamp(y_sum_c, Y_MIN_S, Y_MAX_S);
  end

  logic [2:0] click_c;
  for (genvar gi = 0; gi < 3; gi++) begin : g_click
    assign click_c[gi] = btn_cap_reg[gi] & ~btn_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      motion_reg    <= '0;
      btn_cap_reg   <= '0;
      x_byte_reg    <= '0;
      y_byte_reg    <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      x_posn_reg    <= X_INIT_P;
      y_posn_reg    <= Y_INIT_P;
      btn_reg       <= '0;
      click_reg     <= '0;
      pos_valid_reg <= 1'b0;
      pkt_err_reg   <= 1'b0;
      ready_reg     <= 1'b0;
    end else if (!locked) begin
      // Loss of lock drops any packet in flight and recentres the cursor.
      state_reg     <= IDLE;
      motion_reg    <= '0;
      btn_cap_reg   <= '0;
      x_byte_reg    <= '0;
      y_byte_reg    <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      x_posn_reg    <= X_INIT_P;
      y_posn_reg    <= Y_INIT_P;
      btn_reg       <= '0;
      click_reg     <= '0;
      pos_valid_reg <= 1'b0;
      pkt_err_reg   <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      pos_valid_reg <= 1'b0;
      pkt_err_reg   <= 1'b0;
      click_reg     <= '0;
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (bus.pkt_valid && ready_reg) begin
            if (bus.status_byte[3]) begin
              motion_reg  <= bus.status_byte[7:4];
              btn_cap_reg <= bus.status_byte[2:0];
              x_byte_reg  <= bus.x_byte;
              y_byte_reg  <= bus.y_byte;
              ready_reg   <= 1'b0;
              state_reg   <= SCALE;
            end else begin
              // Bad sync bit: drop the packet, keep accepting every cycle.
              pkt_err_reg <= 1'b1;
            end
          end
        end
        SCALE: begin
          dx_reg    <= scale_delta(motion_reg[2], motion_reg[0], x_byte_reg);
          dy_reg    <= scale_delta(motion_reg[3], motion_reg[1], y_byte_reg);
          state_reg <= UPDATE;
        end
        UPDATE: begin
          x_posn_reg    <= POS_W'(x_clamp_c);
          y_posn_reg    <= POS_W'(y_clamp_c);
          btn_reg       <= btn_cap_reg;
          click_reg     <= click_c;
          pos_valid_reg <= 1'b1;
          ready_reg     <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          ready_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.pkt_ready = ready_reg;
  assign bus.x_posn    = x_posn_reg;
  assign bus.y_posn    = y_posn_reg;
  assign bus.pos_valid = pos_valid_reg;
  assign bus.pkt_err   = pkt_err_reg;
  assign bus.btn       = btn_reg;
  assign bus.click     = click_reg;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb_mouse_cursor_tracker
// Directed packets with hand-computed expected cursor states. Expected
// responses go into a queue when each packet is issued; a monitor pops and
// compares whenever the tracker pulses pos_valid or pkt_err.
// Expected values for the acceleration build follow MOUSE_ACCEL_EN.
module tb_mouse_cursor_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b1;

  always #5 clk = ~clk;

  mouse_cursor_tracker_if #(.POS_W(10)) bus ();

  mouse_cursor_tracker dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .locked (locked),
    .bus    (bus.slave)
  );

  typedef struct {
    logic       err;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [2:0] click;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

`ifdef MOUSE_ACCEL_EN
  localparam logic [9:0] X_V4 = 10'd600, X_V6 = 10'd88,  X_V12 = 10'd384, X_V13 = 10'd399;
`else
  localparam logic [9:0] X_V4 = 10'd575, X_V6 = 10'd344, X_V12 = 10'd352, X_V13 = 10'd367;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pos(input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] b, input logic [2:0] c);
    exp_t e;
    e.err = 1'b0; e.x = x; e.y = y; e.btn = b; e.click = c;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    exp_t e;
    e.err = 1'b1; e.x = x; e.y = y; e.btn = b; e.click = 3'b000;
    exp_q.push_back(e);
  endtask

  // Returns just after the accepting edge k.
  task automatic send(input logic [7:0] s, input logic [7:0] xb, input logic [7:0] yb);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.pkt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pkt_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: pkt_ready got 0, expected 1");
    end
    bus.status_byte = s;
    bus.x_byte      = xb;
    bus.y_byte      = yb;
    bus.pkt_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    $display("send status=%02h x=%02h y=%02h", s, xb, yb);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (bus.pos_valid || bus.pkt_err)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: pos_valid=%0b pkt_err=%0b, expected none",
                 bus.pos_valid, bus.pkt_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("out pos_valid=%0b pkt_err=%0b x=%0d y=%0d btn=%03b click=%03b",
                 bus.pos_valid, bus.pkt_err, bus.x_posn, bus.y_posn, bus.btn, bus.click);
        check("pkt_err",   32'(bus.pkt_err),   32'(e.err));
        check("pos_valid", 32'(bus.pos_valid), 32'(!e.err));
        check("x_posn",    32'(bus.x_posn),    32'(e.x));
        check("y_posn",    32'(bus.y_posn),    32'(e.y));
        check("btn",       32'(bus.btn),       32'(e.btn));
        check("click",     32'(bus.click),     32'(e.click));
      end
    end
  end

  initial begin
    int n;
    bus.pkt_valid   = 1'b0;
    bus.status_byte = 8'h00;
    bus.x_byte      = 8'h00;
    bus.y_byte      = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_x",        32'(bus.x_posn),    32'd320);
    check("rst_y",        32'(bus.y_posn),    32'd240);
    check("rst_ready",    32'(bus.pkt_ready), 32'd0);
    check("rst_posvalid", 32'(bus.pos_valid), 32'd0);
    check("rst_btn",      32'(bus.btn),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.pkt_ready), 32'd1);

    // Basic move with ready-timing check.
    push_pos(10'd325, 10'd237, 3'b000, 3'b000);
    send(8'h08, 8'h05, 8'h03);
    @(negedge clk);
    check("ready_k0", 32'(bus.pkt_ready), 32'd0);
    @(negedge clk);
    check("ready_k1", 32'(bus.pkt_ready), 32'd0);
    @(negedge clk);
    check("ready_k2", 32'(bus.pkt_ready), 32'd1);

    // Lock lost while the packet sits in SCALE: dropped, cursor recentred.
    send(8'h08, 8'h05, 8'h03);
    @(negedge clk);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    check("relock_x",     32'(bus.x_posn),    32'd320);
    check("relock_y",     32'(bus.y_posn),    32'd240);
    check("relock_ready", 32'(bus.pkt_ready), 32'd0);
    locked = 1'b1;
    @(negedge clk);
    check("relock_ready_back", 32'(bus.pkt_ready), 32'd1);

    // Clamp and overflow.
    push_pos(X_V4,    10'd240, 3'b000, 3'b000);
    send(8'h08, 8'hFF, 8'h00);
    push_pos(10'd600, 10'd240, 3'b000, 3'b000);
    send(8'h08, 8'hFF, 8'h00);
    push_pos(X_V6,    10'd240, 3'b000, 3'b000);
    send(8'h58, 8'hFF, 8'h00);

    // Negative Y, then saturated negative Y clamped at the bottom.
    push_pos(X_V6, 10'd250, 3'b000, 3'b000);
    send(8'h28, 8'h00, 8'hF6);
    push_pos(X_V6, 10'd474, 3'b000, 3'b000);
    send(8'hA8, 8'h00, 8'hF6);

    // Sync error, then buttons.
    push_err(X_V6, 10'd474, 3'b000);
    send(8'h00, 8'h00, 8'h00);
    push_pos(X_V6, 10'd474, 3'b001, 3'b001);
    send(8'h09, 8'h00, 8'h00);
    push_pos(X_V6, 10'd474, 3'b001, 3'b000);
    send(8'h09, 8'h00, 8'h00);

    // Relock from IDLE to restart from the centre, then acceleration.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check("idle_relock_btn", 32'(bus.btn),    32'd0);
    check("idle_relock_x",   32'(bus.x_posn), 32'd320);
    locked = 1'b1;
    push_pos(X_V12, 10'd240, 3'b000, 3'b000);
    send(8'h08, 8'h20, 8'h00);
    push_pos(X_V13, 10'd240, 3'b000, 3'b000);
    send(8'h08, 8'h0F, 8'h00);

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
